mux_rr_scheduler: RTL

Round-robin scheduler that shares the 8:1 bit-select multiplexer between eight requesters. It arbitrates the `req` lines, drives the mux `sel[2:0]` with the winner's index and presents the muxed bit to a downstream consumer with a valid/ready handshake. Each grant is bounded to a configurable burst of transfers. The block sits directly in front of the mux's `sel` input; the mux datapath itself is unchanged.

---
 rtl/mux_rr_scheduler.sv | 95 +++++++++
 1 files changed

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler in front of an 8:1 bit-select mux. One requester is granted
// at a time, and each grant is bounded to BURST_MAX accepted transfers.
module mux_rr_scheduler #(
    parameter int BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic [7:0] in,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] beat_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] ptr;
    logic [2:0] ptr_next;
    logic [2:0] sel_next;
    logic [3:0] beat_next;
    logic [2:0] winner;
    logic       found;
    logic       transfer;
    logic       burst_done;

    // Search upward from the last grantee, so it becomes lowest priority this round.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        for (int k = 1; k <= 8; k++) begin
            if (!found && req[ptr + 3'(k)]) begin
                found  = 1'b1;
                winner = ptr + 3'(k);
            end
        end
    end

    assign transfer   = (state == GRANT) && out_ready;
    assign burst_done = transfer && ((beat_cnt + 4'd1) == 4'(BURST_MAX));

    always_comb begin
        state_next = state;
        sel_next   = sel;
        ptr_next   = ptr;
        beat_next  = beat_cnt;
        unique case (state)
            IDLE: begin
                if (en && found) begin
                    state_next = GRANT;
                    sel_next   = winner;
                    ptr_next   = winner;
                    beat_next  = 4'd0;
                end
            end
            GRANT: begin
                // A transfer on the releasing cycle still counts toward beat_cnt.
                if (transfer) begin
                    beat_next = beat_cnt + 4'd1;
                end
                if (burst_done || !req[sel] || !en) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 3'd0;
            ptr      <= 3'd7;
            beat_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            sel      <= sel_next;
            ptr      <= ptr_next;
            beat_cnt <= beat_next;
        end
    end

    // Outputs are decoded straight from registers so an async reset clears them at once.
    assign out_valid = (state == GRANT);
    assign grant     = out_valid ? (8'd1 << sel) : 8'd0;
    assign out       = in[sel];

endmodule
